// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with a one-cycle sign fix-up before writeback.
module muldiv_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       op_a,
  input  logic [XLEN-1:0]       op_b,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  kill,
  output logic                  stall_req,
  output logic                  busy,
  output logic                  result_valid,
  output logic [XLEN-1:0]       result,
  output logic [REG_ADDR_W-1:0] rd_out
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned ACC_W = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [XLEN-1:0]         b_q, b_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              f3_q, f3_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic                    neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic                    result_valid_q, result_valid_d;
  logic [XLEN-1:0]         result_q, result_d;
  logic [REG_ADDR_W-1:0]   rd_out_q, rd_out_d;

  logic                    a_signed, b_signed, in_neg_a, in_neg_b;
  logic [XLEN-1:0]         abs_a, abs_b;
  logic [XLEN:0]           mul_sum;
  logic [ACC_W-1:0]        mul_next;
  logic [XLEN:0]           div_rsh;
  logic [XLEN+1:0]         div_sub;
  logic                    div_neg;
  logic [ACC_W-1:0]        div_next;
  logic [ACC_W-1:0]        prod_fix;
  logic [XLEN-1:0]         quo_fix, rem_fix;

  // Operand signedness per funct3: MULHSU treats only rs1 as signed.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:                         a_signed = 1'b1;
      default: ;
    endcase
  end

  assign in_neg_a = a_signed & op_a[XLEN-1];
  assign in_neg_b = b_signed & op_b[XLEN-1];
  assign abs_a    = in_neg_a ? XLEN'(-op_a) : op_a;
  assign abs_b    = in_neg_b ? XLEN'(-op_b) : op_b;

  // Multiply step: add multiplicand into the high half when lsb set, then shift right.
  assign mul_sum  = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : (XLEN+1)'(0));
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide step: shift {rem, quo} left, keep the trial subtraction when it does not borrow.
  assign div_rsh  = acc_q[ACC_W-1:XLEN-1];
  assign div_sub  = {1'b0, div_rsh} - (XLEN+2)'(b_q);
  assign div_neg  = div_sub[XLEN+1];
  assign div_next = {(div_neg ? div_rsh[XLEN-1:0] : div_sub[XLEN-1:0]),
                     acc_q[XLEN-2:0], ~div_neg};

  assign prod_fix = (neg_a_q ^ neg_b_q) ? ACC_W'(-acc_q) : acc_q;
  assign quo_fix  = (neg_a_q ^ neg_b_q) ? XLEN'(-acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
  assign rem_fix  = neg_a_q ? XLEN'(-acc_q[ACC_W-1:XLEN]) : acc_q[ACC_W-1:XLEN];

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    b_d            = b_q;
    cnt_d          = cnt_q;
    f3_d           = f3_q;
    rd_d           = rd_q;
    neg_a_d        = neg_a_q;
    neg_b_d        = neg_b_q;
    result_valid_d = 1'b0;
    result_d       = result_q;
    rd_out_d       = rd_out_q;

    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          f3_d    = funct3;
          rd_d    = rd_in;
          neg_a_d = in_neg_a;
          neg_b_d = in_neg_b;
          if (funct3[2] && op_b == '0) begin
            result_d = funct3[1] ? op_a : '1;
            state_d  = DONE;
          end else if (funct3[2] && !funct3[0] && op_a == MIN_NEG && op_b == '1) begin
            result_d = funct3[1] ? '0 : MIN_NEG;
            state_d  = DONE;
          end else begin
            acc_d   = {XLEN'(0), abs_a};
            b_d     = abs_b;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = f3_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = FIXUP;
      end
      FIXUP: begin
        case (f3_q)
          3'b000:         result_d = prod_fix[XLEN-1:0];
          3'b100, 3'b101: result_d = quo_fix;
          3'b110, 3'b111: result_d = rem_fix;
          default:        result_d = prod_fix[ACC_W-1:XLEN];
        endcase
        state_d = DONE;
      end
      DONE: begin
        result_valid_d = 1'b1;
        rd_out_d       = rd_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush drops the operation without touching the writeback outputs.
    if (kill) begin
      state_d        = IDLE;
      result_valid_d = 1'b0;
      result_d       = result_q;
      rd_out_d       = rd_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      b_q            <= '0;
      cnt_q          <= '0;
      f3_q           <= '0;
      rd_q           <= '0;
      neg_a_q        <= 1'b0;
      neg_b_q        <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      rd_out_q       <= '0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      b_q            <= b_d;
      cnt_q          <= cnt_d;
      f3_q           <= f3_d;
      rd_q           <= rd_d;
      neg_a_q        <= neg_a_d;
      neg_b_q        <= neg_b_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      rd_out_q       <= rd_out_d;
    end
  end

  assign stall_req    = (state_q == IDLE && start && !kill) || state_q == CALC || state_q == FIXUP;
  assign busy         = (state_q != IDLE);
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign rd_out       = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: RV32M results, latency, stall window, kill/reset aborts.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        kill;
  logic        stall_req, busy, result_valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .kill(kill),
    .stall_req(stall_req), .busy(busy), .result_valid(result_valid),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  // Issues one op and waits (bounded) for result_valid; lat = edges after E0, -1 on timeout.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output int stall_cnt,
                        output logic pre_stall, output logic [31:0] res, output logic [4:0] rdo);
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    #1 pre_stall = stall_req;
    @(posedge clk);
    #1 start = 1'b0;
    stall_cnt = stall_req ? 1 : 0;
    lat = -1; res = '0; rdo = '0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (result_valid) begin
        lat = i; res = result; rdo = rd_out;
        break;
      end
      if (stall_req) stall_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", result_valid); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
    n_cmp++; if (rd_out !== 5'd0) begin n_err++; $display("FAIL reset_rd got %0d want 0", rd_out); end
    n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall_req); end
  endtask

  task automatic test_mul_basic();
    int lat, sc; logic ps; logic [31:0] r; logic [4:0] rdo;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd9, lat, sc, ps, r, rdo);
    n_cmp++; if (r !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_result got %h want ffffffeb", r); end
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL mul_latency got %0d want 34", lat); end
    n_cmp++; if (rdo !== 5'd9) begin n_err++; $display("FAIL mul_rd got %0d want 9", rdo); end
    n_cmp++; if (ps !== 1'b1) begin n_err++; $display("FAIL mul_stall_at_issue got %b want 1", ps); end
    n_cmp++; if (sc !== 33) begin n_err++; $display("FAIL mul_stall_cycles got %0d want 33", sc); end
    @(posedge clk); #1;
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL mul_valid_pulse got %b want 0", result_valid); end
  endtask

  // Normal-path vectors: high-half multiplies and signed/unsigned divides.
  task automatic test_arith();
    logic [2:0]  f [6] = '{3'b011, 3'b001, 3'b010, 3'b100, 3'b110, 3'b101};
    logic [31:0] a [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] b [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 32'd2, 32'd2, 32'd2};
    logic [31:0] e [6] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC};
    int lat, sc; logic ps; logic [31:0] r; logic [4:0] rdo;
    for (int i = 0; i < 6; i++) begin
      run_op(f[i], a[i], b[i], 5'(i + 1), lat, sc, ps, r, rdo);
      n_cmp++; if (r !== e[i]) begin n_err++; $display("FAIL arith%0d_result got %h want %h", i, r, e[i]); end
      n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL arith%0d_latency got %0d want 34", i, lat); end
      n_cmp++; if (rdo !== 5'(i + 1)) begin n_err++; $display("FAIL arith%0d_rd got %0d want %0d", i, rdo, i + 1); end
    end
  endtask

  // Divide-by-zero and signed overflow bypass the iteration.
  task automatic test_special();
    logic [2:0]  f [4] = '{3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] a [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] e [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int lat, sc; logic ps; logic [31:0] r; logic [4:0] rdo;
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], a[i], b[i], 5'd0, lat, sc, ps, r, rdo);
      n_cmp++; if (r !== e[i]) begin n_err++; $display("FAIL special%0d_result got %h want %h", i, r, e[i]); end
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL special%0d_latency got %0d want 1", i, lat); end
      n_cmp++; if (sc !== 0) begin n_err++; $display("FAIL special%0d_stall got %0d want 0", i, sc); end
    end
  endtask

  task automatic test_start_ignored();
    int pulses = 0; int first = -1; logic [31:0] r = '0;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd7; op_b = 32'hFFFF_FFFD; rd_in = 5'd3;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 10) begin
        start = 1'b1; funct3 = 3'b000; op_a = 32'd2; op_b = 32'd3; rd_in = 5'd4;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (result_valid) begin
        pulses++;
        if (first < 0) begin first = i; r = result; end
      end
    end
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
    n_cmp++; if (first !== 34) begin n_err++; $display("FAIL ignore_latency got %0d want 34", first); end
    n_cmp++; if (r !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL ignore_result got %h want ffffffeb", r); end
  endtask

  // Aborts at E0+15 via kill (abort=0) or reset (abort=1); prior result is ffffffeb.
  task automatic test_abort(input bit use_reset);
    int pulses = 0;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b011; op_a = 32'd100; op_b = 32'd200; rd_in = 5'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    if (use_reset) reset = 1'b1; else kill = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; kill = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort%0d_busy got %b want 0", use_reset, busy); end
    n_cmp++; if (result !== (use_reset ? 32'h0 : 32'hFFFF_FFEB)) begin
      n_err++; $display("FAIL abort%0d_result got %h want %h", use_reset, result, use_reset ? 32'h0 : 32'hFFFF_FFEB);
    end
    for (int i = 0; i < 30; i++) begin
      if (result_valid) pulses++;
      @(posedge clk); #1;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL abort%0d_valid got %0d pulses want 0", use_reset, pulses); end
  endtask

  task automatic test_kill_start();
    @(negedge clk);
    start = 1'b1; kill = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd1;
    #1;
    n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL killstart_stall got %b want 0", stall_req); end
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL killstart_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_arith();
    test_special();
    test_start_ignored();
    test_abort(1'b0);
    test_abort(1'b1);
    test_kill_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
